dumbrv_spi_master: RTL

DUMBRV_SPI_MASTER -- requirements
Module: dumbrv_spi_master

---
 rtl/dumbrv_spi_pkg.sv | 19 +
 rtl/dumbrv_spi_clkdiv.sv | 37 +++
 rtl/dumbrv_spi_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dumbrv_spi_pkg.sv
// dumbrv_spi_pkg: shared FSM state encoding and SPI mode constants
// for the dumbrv SPI master.
package dumbrv_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_ACTIVE,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    localparam logic CPOL_LOW         = 1'b0;
    localparam logic CPOL_HIGH        = 1'b1;
    localparam logic CPHA_SAMPLE_LEAD = 1'b0;
    localparam logic CPHA_SHIFT_LEAD  = 1'b1;

endpackage

// File: rtl/dumbrv_spi_clkdiv.sv
// dumbrv_spi_clkdiv: half-period tick generator, tick every div_i+1
// cycles; restart_i holds the count at zero.
module dumbrv_spi_clkdiv
    import dumbrv_spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = (cnt_q == div_i);

    // Wrap on tick so back-to-back halves have equal length.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dumbrv_spi_master.sv
// dumbrv_spi_master: SPI master with per-word chip-select control,
// runtime mode and divider, MSB-first shifter.
module dumbrv_spi_master
    import dumbrv_spi_pkg::*;
#(
    parameter int NUM_CS = 2,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CS_W-1:0]   req_cs,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_last,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs
);

    localparam int HC_W = $clog2(2 * DATA_W);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * DATA_W - 1);

    spi_state_e        state_q;
    logic [DIV_W-1:0]  div_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [CS_W-1:0]   idx_q;
    logic              last_q;
    logic              pend_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rdata_q;
    logic [HC_W-1:0]   hcnt_q;
    logic [NUM_CS-1:0] cs_q;
    logic              sck_q;
    logic              mosi_q;
    logic              rsp_q;
    logic              tick;
    logic              restart;

    // Out-of-range indices decode to no select at all.
    function automatic logic [NUM_CS-1:0] cs_dec(
        input logic [CS_W-1:0] idx
    );
        logic [NUM_CS-1:0] d;
        for (int i = 0; i < NUM_CS; i++) begin
            d[i] = (idx == CS_W'(i));
        end
        return d;
    endfunction

    // Sample-first mode pre-shifts since the MSB already sits on mosi.
    function automatic logic [DATA_W-1:0] tx_init(
        input logic [DATA_W-1:0] w,
        input logic              cpha
    );
        return (cpha == CPHA_SHIFT_LEAD) ? w : (w << 1);
    endfunction

    assign restart   = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign req_ready = restart;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs    = cs_q;

    dumbrv_spi_clkdiv #(
        .DIV_W(DIV_W)
    ) u_clkdiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(restart),
        .div_i    (div_q),
        .tick_o   (tick)
    );

    // Transfer FSM, shifter and chip-select register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            wdata_q <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            hcnt_q  <= '0;
            cs_q    <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            rsp_q   <= 1'b0;
        end else begin
            rsp_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    sck_q <= cfg_cpol;
                    if (req_valid) begin
                        div_q   <= cfg_div;
                        cpol_q  <= cfg_cpol;
                        cpha_q  <= cfg_cpha;
                        idx_q   <= req_cs;
                        last_q  <= req_last;
                        cs_q    <= cs_dec(req_cs);
                        mosi_q  <= req_wdata[DATA_W-1];
                        tx_q    <= tx_init(req_wdata, cfg_cpha);
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        sck_q   <= ~sck_q;
                        hcnt_q  <= '0;
                        state_q <= ST_SHIFT;
                        if (cpha_q == CPHA_SAMPLE_LEAD) begin
                            rx_q <= {rx_q[DATA_W-2:0], spi_miso};
                        end else begin
                            mosi_q <= tx_q[DATA_W-1];
                            tx_q   <= tx_q << 1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tick && (hcnt_q == HC_LAST)) begin
                        rsp_q   <= 1'b1;
                        rdata_q <= rx_q;
                        state_q <= last_q ? ST_HOLD : ST_ACTIVE;
                    end else if (tick) begin
                        sck_q  <= ~sck_q;
                        hcnt_q <= hcnt_q + 1'b1;
                        if (hcnt_q[0] ^ (cpha_q == CPHA_SHIFT_LEAD)) begin
                            rx_q <= {rx_q[DATA_W-2:0], spi_miso};
                        end else begin
                            mosi_q <= tx_q[DATA_W-1];
                            tx_q   <= tx_q << 1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    sck_q <= cpol_q;
                    if (req_valid) begin
                        idx_q  <= req_cs;
                        last_q <= req_last;
                        if (req_cs == idx_q) begin
                            mosi_q  <= req_wdata[DATA_W-1];
                            tx_q    <= tx_init(req_wdata, cpha_q);
                            state_q <= ST_SETUP;
                        end else begin
                            wdata_q <= req_wdata;
                            pend_q  <= 1'b1;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        cs_q    <= '0;
                        sck_q   <= cpol_q;
                        state_q <= pend_q ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        pend_q  <= 1'b0;
                        cs_q    <= cs_dec(idx_q);
                        mosi_q  <= wdata_q[DATA_W-1];
                        tx_q    <= tx_init(wdata_q, cpha_q);
                        state_q <= ST_SETUP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
